bsg_cache_pkt_encode: RTL and testbench

Client-side issuer for bsg_cache: accepts high-level memory commands over a valid/ready port, encodes them into the 116-bit cache packet (opcode, address, lane-replicated store data, mask), and drives the cache's packet input through a one-entry output register. Tracks outstanding requests with a credit counter, forwards cache responses, and implements a client FENCE pseudo-op. Sits between a core/DMA client and the cache's packet-decode front end.

---
 rtl/bsg_cache_pkg.sv | 61 ++++++
 rtl/bsg_cache_pkt_encode_store_align.sv | 34 +++
 rtl/bsg_cache_pkt_encode.sv | 159 +++++++++++++++
 tb/tb_bsg_cache_pkt_encode.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_cache_pkg.sv
// Shared definitions for the bsg_cache client-side packet encoder:
// opcodes, FENCE pseudo-op, packet layout/width and encoder FSM states.
package bsg_cache_pkg;

    typedef enum logic [4:0] {
        OP_LB      = 5'b00000,
        OP_LH      = 5'b00001,
        OP_LW      = 5'b00010,
        OP_LD      = 5'b00011,
        OP_LBU     = 5'b00100,
        OP_LHU     = 5'b00101,
        OP_LWU     = 5'b00110,
        OP_LDU     = 5'b00111,
        OP_SB      = 5'b01000,
        OP_SH      = 5'b01001,
        OP_SW      = 5'b01010,
        OP_SD      = 5'b01011,
        OP_LM      = 5'b01100,
        OP_SM      = 5'b01101,
        OP_TAGST   = 5'b10000,
        OP_TAGFL   = 5'b10001,
        OP_TAGLV   = 5'b10010,
        OP_TAGLA   = 5'b10011,
        OP_AFL     = 5'b11000,
        OP_AFLINV  = 5'b11001,
        OP_AINV    = 5'b11010,
        OP_ALOCK   = 5'b11011,
        OP_AUNLOCK = 5'b11100
    } bsg_cache_opcode_e;

    // Client-only code; never forwarded to the cache.
    localparam logic [4:0] FENCE_OP = 5'b11111;

    localparam int DEF_ADDR_W = 39;
    localparam int DEF_DATA_W = 64;

    typedef struct packed {
        logic [4:0]              opcode;
        logic [DEF_ADDR_W-1:0]   addr;
        logic [DEF_DATA_W-1:0]   data;
        logic [DEF_DATA_W/8-1:0] mask;
    } bsg_cache_pkt_s;

    typedef enum logic {
        ST_IDLE,
        ST_FENCE_WAIT
    } encode_state_e;

    function automatic int cache_pkt_width(input int addr_w, input int data_w);
        return 5 + addr_w + data_w + data_w / 8;
    endfunction

    function automatic logic is_store(input logic [4:0] op);
        return op[4:2] == 3'b010;
    endfunction

    function automatic logic is_load(input logic [4:0] op);
        return op[4:3] == 2'b00;
    endfunction

endpackage

// File: rtl/bsg_cache_pkt_encode_store_align.sv
// Replicates the low 2^opcode[1:0] bytes of store data across every byte lane;
// non-store opcodes produce zero.
module bsg_cache_pkt_encode_store_align
    import bsg_cache_pkg::*;
#(
    parameter int data_width_p = 64
)
(
    input  logic [4:0]              i_opcode,
    input  logic [data_width_p-1:0] i_data,
    output logic [data_width_p-1:0] o_data
);

    localparam int LANES = data_width_p / 8;

    logic w_store;
    assign w_store = is_store(i_opcode);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [7:0] w_byte;
        // Lane gi takes byte (gi mod size) of the right-justified source.
        always_comb begin
            w_byte = 8'h00;
            case (i_opcode[1:0])
                2'd0:    w_byte = i_data[7:0];
                2'd1:    w_byte = i_data[(gi % 2) * 8 +: 8];
                2'd2:    w_byte = i_data[(gi % 4) * 8 +: 8];
                default: w_byte = i_data[(gi % 8) * 8 +: 8];
            endcase
        end
        assign o_data[gi * 8 +: 8] = w_store ? w_byte : 8'h00;
    end

endmodule

// File: rtl/bsg_cache_pkt_encode.sv
// Client-side bsg_cache issuer: encodes commands into cache packets, tracks credits,
// implements FENCE. Optional alignment check: BSG_CACHE_PKT_ENCODE_ALIGN_CHECK_EN.
module bsg_cache_pkt_encode
    import bsg_cache_pkg::*;
#(
    parameter int addr_width_p      = 39,
    parameter int data_width_p      = 64,
    parameter int outstanding_els_p = 4
)
(
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic                        v_i,
    input  logic [4:0]                  opcode_i,
    input  logic [addr_width_p-1:0]     addr_i,
    input  logic [data_width_p-1:0]     data_i,
    input  logic [data_width_p/8-1:0]   mask_i,
    output logic                        ready_o,

    output logic [cache_pkt_width(addr_width_p, data_width_p)-1:0] cache_pkt_o,
    output logic                        cache_pkt_v_o,
    input  logic                        cache_pkt_ready_i,

    input  logic                        cache_v_i,
    input  logic [data_width_p-1:0]     cache_data_i,
    output logic                        cache_yumi_o,

    output logic                        resp_v_o,
    output logic [data_width_p-1:0]     resp_data_o,
    input  logic                        resp_yumi_i,

    output logic                        fence_done_o,
    output logic                        error_o
);

    localparam int MASK_W = data_width_p / 8;
    localparam int PKT_W  = cache_pkt_width(addr_width_p, data_width_p);
    localparam int CNT_W  = $clog2(outstanding_els_p + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(outstanding_els_p);

    encode_state_e            r_state;
    encode_state_e            w_state_next;
    logic                     r_pkt_v;
    logic [PKT_W-1:0]         r_pkt;
    logic [CNT_W-1:0]         r_cnt;

    logic                     w_is_fence;
    logic                     w_accept;
    logic                     w_drop;
    logic                     w_issue;
    logic                     w_fence_done;
    logic [data_width_p-1:0]  w_store_data;
    logic [data_width_p-1:0]  w_data;
    logic [MASK_W-1:0]        w_mask;

    assign w_is_fence = (opcode_i == FENCE_OP);
    assign ready_o    = (r_state == ST_IDLE)
                      & (w_is_fence | ((~r_pkt_v | cache_pkt_ready_i) & (r_cnt != CNT_MAX)));
    assign w_accept   = v_i & ready_o;
    assign w_issue    = w_accept & ~w_is_fence & ~w_drop;

    bsg_cache_pkt_encode_store_align #(
        .data_width_p (data_width_p)
    ) u_store_align (
        .i_opcode (opcode_i),
        .i_data   (data_i),
        .o_data   (w_store_data)
    );

    always_comb begin
        w_data = w_store_data;
        w_mask = '0;
        if (opcode_i == OP_SM) begin
            w_data = data_i;
            w_mask = mask_i;
        end else if (opcode_i == OP_LM) begin
            w_mask = mask_i;
        end
    end

`ifdef BSG_CACHE_PKT_ENCODE_ALIGN_CHECK_EN
    logic [2:0] w_align_mask;
    logic       r_err;

    always_comb begin
        case (opcode_i[1:0])
            2'd0:    w_align_mask = 3'b000;
            2'd1:    w_align_mask = 3'b001;
            2'd2:    w_align_mask = 3'b011;
            default: w_align_mask = 3'b111;
        endcase
    end

    assign w_drop = (is_load(opcode_i) | is_store(opcode_i)) & (|(addr_i[2:0] & w_align_mask));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_err <= 1'b0;
        end else if (w_accept & w_drop) begin
            r_err <= 1'b1;
        end
    end

    assign error_o = r_err;
`else
    assign w_drop  = 1'b0;
    assign error_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_pkt_v <= 1'b0;
            r_pkt   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_issue) begin
                r_pkt_v <= 1'b1;
                r_pkt   <= {opcode_i, addr_i, w_data, w_mask};
            end else if (cache_pkt_ready_i) begin
                r_pkt_v <= 1'b0;
            end
            // Credit taken at accept so a fence waits on a packet still in the register.
            if (w_issue & ~cache_yumi_o) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (~w_issue & cache_yumi_o) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fence_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept & w_is_fence) begin
                    w_state_next = ST_FENCE_WAIT;
                end
            end
            ST_FENCE_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_IDLE;
                    w_fence_done = 1'b1;
                end
            end
        endcase
    end

    assign cache_pkt_o   = r_pkt;
    assign cache_pkt_v_o = r_pkt_v;
    assign fence_done_o  = w_fence_done;
    assign cache_yumi_o  = resp_yumi_i & cache_v_i;
    assign resp_v_o      = cache_v_i;
    assign resp_data_o   = cache_data_i;

endmodule

// File: tb/tb_bsg_cache_pkt_encode.sv
// Directed bench for bsg_cache_pkt_encode; alignment checks follow
// BSG_CACHE_PKT_ENCODE_ALIGN_CHECK_EN when it is defined for the build.
module tb_bsg_cache_pkt_encode;

    localparam int AW = 39;
    localparam int DW = 64;
    localparam int MW = 8;
    localparam int PW = 5 + AW + DW + MW;

    localparam logic [4:0] C_LB = 5'b00000;
    localparam logic [4:0] C_LW = 5'b00010;
    localparam logic [4:0] C_LD = 5'b00011;
    localparam logic [4:0] C_SB = 5'b01000;
    localparam logic [4:0] C_SH = 5'b01001;
    localparam logic [4:0] C_SW = 5'b01010;
    localparam logic [4:0] C_SD = 5'b01011;
    localparam logic [4:0] C_LM = 5'b01100;
    localparam logic [4:0] C_SM = 5'b01101;
    localparam logic [4:0] C_FENCE = 5'b11111;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          v_i;
    logic [4:0]    opcode_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] data_i;
    logic [MW-1:0] mask_i;
    logic          ready_o;
    logic [PW-1:0] cache_pkt_o;
    logic          cache_pkt_v_o;
    logic          cache_pkt_ready_i;
    logic          cache_v_i;
    logic [DW-1:0] cache_data_i;
    logic          cache_yumi_o;
    logic          resp_v_o;
    logic [DW-1:0] resp_data_o;
    logic          resp_yumi_i;
    logic          fence_done_o;
    logic          error_o;

    always #5 clk_i = ~clk_i;

    bsg_cache_pkt_encode #(
        .addr_width_p      (AW),
        .data_width_p      (DW),
        .outstanding_els_p (4)
    ) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .v_i               (v_i),
        .opcode_i          (opcode_i),
        .addr_i            (addr_i),
        .data_i            (data_i),
        .mask_i            (mask_i),
        .ready_o           (ready_o),
        .cache_pkt_o       (cache_pkt_o),
        .cache_pkt_v_o     (cache_pkt_v_o),
        .cache_pkt_ready_i (cache_pkt_ready_i),
        .cache_v_i         (cache_v_i),
        .cache_data_i      (cache_data_i),
        .cache_yumi_o      (cache_yumi_o),
        .resp_v_o          (resp_v_o),
        .resp_data_o       (resp_data_o),
        .resp_yumi_i       (resp_yumi_i),
        .fence_done_o      (fence_done_o),
        .error_o           (error_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("ok   %s = %h", tag, obs);
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] pkt(input logic [4:0] op, input logic [AW-1:0] a,
                                          input logic [DW-1:0] d, input logic [MW-1:0] m);
        return {op, a, d, m};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cmd(input logic [4:0] op, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [MW-1:0] m);
        v_i = 1'b1; opcode_i = op; addr_i = a; data_i = d; mask_i = m;
        #1;
    endtask

    task automatic idle();
        v_i = 1'b0;
        #1;
    endtask

    task automatic respond(input int n);
        cache_v_i = 1'b1; resp_yumi_i = 1'b1; cache_data_i = 64'h0123_4567_89AB_CDEF;
        repeat (n) tick();
        cache_v_i = 1'b0; resp_yumi_i = 1'b0;
        #1;
    endtask

    initial begin
        reset_i = 1'b1; v_i = 1'b0; opcode_i = '0; addr_i = '0; data_i = '0; mask_i = '0;
        cache_pkt_ready_i = 1'b1; cache_v_i = 1'b0; cache_data_i = '0; resp_yumi_i = 1'b0;
        tick(); tick();
        check("rst_pkt_v", 128'(cache_pkt_v_o), 128'd0);
        check("rst_pkt", 128'(cache_pkt_o), 128'd0);
        check("rst_fence_done", 128'(fence_done_o), 128'd0);
        check("rst_error", 128'(error_o), 128'd0);
        reset_i = 1'b0;
        #1;

        // SB replicates the low byte; mask forced to zero
        cmd(C_SB, 39'h10, 64'h0000_0000_0000_00AB, 8'hFF);
        check("sb_ready", 128'(ready_o), 128'd1);
        tick(); idle();
        check("sb_pkt_v", 128'(cache_pkt_v_o), 128'd1);
        check("sb_pkt", 128'(cache_pkt_o), 128'(pkt(C_SB, 39'h10, 64'hABAB_ABAB_ABAB_ABAB, 8'h00)));
        cache_v_i = 1'b1; cache_data_i = 64'h0000_0000_0000_55AA; resp_yumi_i = 1'b0;
        #1;
        check("resp_v", 128'(resp_v_o), 128'd1);
        check("resp_data", 128'(resp_data_o), 128'h55AA);
        check("yumi_gated", 128'(cache_yumi_o), 128'd0);
        resp_yumi_i = 1'b1;
        #1;
        check("yumi", 128'(cache_yumi_o), 128'd1);
        tick();
        cache_v_i = 1'b0; resp_yumi_i = 1'b0;
        #1;
        check("sb_pkt_clear", 128'(cache_pkt_v_o), 128'd0);

        // SW held while cache stalls, SH accepted on the handshake cycle
        cache_pkt_ready_i = 1'b0;
        cmd(C_SW, 39'h20, 64'hDEAD_BEEF_1234_5678, 8'h00);
        check("sw_ready", 128'(ready_o), 128'd1);
        tick();
        cmd(C_SH, 39'h30, 64'h0000_0000_0000_BEEF, 8'h00);
        for (int i = 0; i < 3; i++) begin
            check("sw_stall_ready", 128'(ready_o), 128'd0);
            check("sw_stall_v", 128'(cache_pkt_v_o), 128'd1);
            check("sw_stall_pkt", 128'(cache_pkt_o),
                  128'(pkt(C_SW, 39'h20, 64'h1234_5678_1234_5678, 8'h00)));
            tick();
        end
        cache_pkt_ready_i = 1'b1;
        #1;
        check("sh_ready_on_hs", 128'(ready_o), 128'd1);
        tick(); idle();
        check("sh_pkt", 128'(cache_pkt_o), 128'(pkt(C_SH, 39'h30, 64'hBEEF_BEEF_BEEF_BEEF, 8'h00)));
        respond(2);

        // Credit limit: four loads fill the counter
        for (int k = 0; k < 4; k++) begin
            cmd(C_LD, 39'(32'h100 + 8 * k), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
            check("ld_ready", 128'(ready_o), 128'd1);
            tick();
        end
        cmd(C_LD, 39'h200, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        check("ld5_blocked", 128'(ready_o), 128'd0);
        check("ld4_pkt", 128'(cache_pkt_o), 128'(pkt(C_LD, 39'h118, 64'd0, 8'h00)));
        cache_v_i = 1'b1; resp_yumi_i = 1'b1;
        #1;
        check("ld5_blocked_same_cycle", 128'(ready_o), 128'd0);
        tick();
        cache_v_i = 1'b0; resp_yumi_i = 1'b0;
        #1;
        check("ld5_reopened", 128'(ready_o), 128'd1);
        tick(); idle();
        check("ld_full_again", 128'(ready_o), 128'd0);
        check("ld5_pkt", 128'(cache_pkt_o), 128'(pkt(C_LD, 39'h200, 64'd0, 8'h00)));
        respond(4);

        // FENCE behind two outstanding loads
        cmd(C_LW, 39'h300, 64'd0, 8'h00); tick();
        cmd(C_LW, 39'h308, 64'd0, 8'h00); tick();
        cmd(C_FENCE, 39'h0, 64'd0, 8'h00);
        check("fence_ready", 128'(ready_o), 128'd1);
        tick(); idle();
        check("fence_wait_ready", 128'(ready_o), 128'd0);
        check("fence_early", 128'(fence_done_o), 128'd0);
        tick();
        check("fence_wait_ready2", 128'(ready_o), 128'd0);
        cache_v_i = 1'b1; resp_yumi_i = 1'b1;
        #1;
        check("fence_cnt2", 128'(fence_done_o), 128'd0);
        tick();
        check("fence_cnt1", 128'(fence_done_o), 128'd0);
        tick();
        cache_v_i = 1'b0; resp_yumi_i = 1'b0;
        #1;
        check("fence_done", 128'(fence_done_o), 128'd1);
        check("fence_done_ready", 128'(ready_o), 128'd0);
        tick();
        check("fence_pulse_end", 128'(fence_done_o), 128'd0);
        check("fence_after_ready", 128'(ready_o), 128'd1);

        // FENCE with nothing outstanding
        cmd(C_FENCE, 39'h0, 64'd0, 8'h00);
        check("fence0_ready", 128'(ready_o), 128'd1);
        tick(); idle();
        check("fence0_done", 128'(fence_done_o), 128'd1);
        check("fence0_ready_wait", 128'(ready_o), 128'd0);
        check("fence0_no_pkt", 128'(cache_pkt_v_o), 128'd0);
        tick();
        check("fence0_pulse_end", 128'(fence_done_o), 128'd0);
        check("fence0_idle_ready", 128'(ready_o), 128'd1);

        // Misaligned LW
        cmd(C_LW, 39'h3, 64'h77, 8'hFF);
        tick(); idle();
`ifdef BSG_CACHE_PKT_ENCODE_ALIGN_CHECK_EN
        check("mis_no_pkt", 128'(cache_pkt_v_o), 128'd0);
        check("mis_error", 128'(error_o), 128'd1);
        tick();
        check("mis_error_sticky", 128'(error_o), 128'd1);
`else
        check("mis_pkt_v", 128'(cache_pkt_v_o), 128'd1);
        check("mis_pkt", 128'(cache_pkt_o), 128'(pkt(C_LW, 39'h3, 64'd0, 8'h00)));
        check("mis_no_error", 128'(error_o), 128'd0);
        respond(1);
`endif
        tick();

        // Reset with a packet held and three credits in use
        for (int k = 0; k < 3; k++) begin
            cmd(C_LD, 39'(32'h400 + 8 * k), 64'd0, 8'h00);
            tick();
        end
        cache_pkt_ready_i = 1'b0;
        idle();
        check("pre_rst_pkt_v", 128'(cache_pkt_v_o), 128'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        #1;
        check("mid_rst_pkt_v", 128'(cache_pkt_v_o), 128'd0);
        check("mid_rst_pkt", 128'(cache_pkt_o), 128'd0);
        check("mid_rst_fence", 128'(fence_done_o), 128'd0);
        check("mid_rst_error", 128'(error_o), 128'd0);
        cache_pkt_ready_i = 1'b1;

        // Four accepts after reset prove the credits were cleared
        cmd(C_SM, 39'h40, 64'h1122_3344_5566_7788, 8'h0F);
        check("sm_ready", 128'(ready_o), 128'd1);
        tick();
        cmd(C_LM, 39'h48, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0);
        check("lm_ready", 128'(ready_o), 128'd1);
        check("sm_pkt", 128'(cache_pkt_o), 128'(pkt(C_SM, 39'h40, 64'h1122_3344_5566_7788, 8'h0F)));
        tick();
        cmd(C_SD, 39'h50, 64'h0102_0304_0506_0708, 8'hFF);
        check("sd_ready", 128'(ready_o), 128'd1);
        check("lm_pkt", 128'(cache_pkt_o), 128'(pkt(C_LM, 39'h48, 64'd0, 8'hF0)));
        tick();
        cmd(C_LB, 39'h5, 64'h0000_0000_0000_00CD, 8'hFF);
        check("lb_ready", 128'(ready_o), 128'd1);
        check("sd_pkt", 128'(cache_pkt_o), 128'(pkt(C_SD, 39'h50, 64'h0102_0304_0506_0708, 8'h00)));
        tick(); idle();
        check("lb_pkt", 128'(cache_pkt_o), 128'(pkt(C_LB, 39'h5, 64'd0, 8'h00)));
        check("post_rst_full", 128'(ready_o), 128'd0);
        respond(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
